// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG entropy block path.
// Holds the block sequencer state set and the JPEG code limits.
package jpeg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HUFF,
      ST_MAG,
      ST_EMIT,
      ST_ZRUN,
      ST_FILL
   } state_e;

   localparam int         BLOCK_LEN = 64;
   localparam int         ZRL_LEN   = 16;
   localparam int         MAG_W     = 11;
   localparam logic [7:0] EOB_RS    = 8'h00;
   localparam logic [7:0] ZRL_RS    = 8'hF0;
   localparam logic [3:0] DC_MAX_S  = 4'd11;
   localparam logic [3:0] AC_MAX_S  = 4'd10;
   localparam logic [5:0] LAST_IDX  = 6'(BLOCK_LEN - 1);

endpackage

// File: rtl/magnitude_extend.sv
// Turns s raw magnitude bits into a signed coefficient value.
// A leading 0 marks a negative value sent as (bits - (2^s - 1)).
module magnitude_extend
   import jpeg_pkg::*;
#(
   parameter int COEF_W = 12
) (
   input  logic [MAG_W-1:0]         raw,
   input  logic [3:0]               s,
   output logic signed [COEF_W-1:0] value
);

   logic [COEF_W-1:0] raw_x;
   logic [COEF_W-1:0] span;
   logic              lead;

   // Pick the MSB of the s-bit field and apply the JPEG extend rule
   always_comb begin
      raw_x = COEF_W'(raw);
      span  = (COEF_W'(1) << s) - COEF_W'(1);
      lead  = 1'b0;
      value = '0;
      if (s != 4'd0) begin
         lead  = raw[s - 4'd1];
         value = lead ? raw_x : raw_x - span;
      end
   end

endmodule

// File: rtl/entropy_block_sequencer.sv
// Walks one 8x8 block: DC code, AC codes, magnitudes, zero runs.
// Emits exactly 64 zig-zag coefficients per block downstream.
module entropy_block_sequencer
   import jpeg_pkg::*;
#(
   parameter int COEF_W = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     pred_clear,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   output logic                     bit_ready,
   output logic                     dec_ac_dc_flag,
   output logic                     dec_next_bit,
   output logic                     dec_is_new,
   input  logic [3:0]               dec_r,
   input  logic [3:0]               dec_s,
   input  logic                     dec_done,
   output logic signed [COEF_W-1:0] coef_value,
   output logic [5:0]               coef_index,
   output logic                     coef_valid,
   input  logic                     coef_ready,
   output logic                     block_done,
   output logic                     busy,
   output logic                     err
);

   state_e                   state;
   logic [5:0]               idx;
   logic [3:0]               s_q;
   logic [4:0]               zcnt;
   logic                     zrl;
   logic [MAG_W-2:0]         mag;
   logic [3:0]               mcnt;
   logic signed [COEF_W-1:0] pred;

   logic [MAG_W-1:0]         mag_nxt;
   logic signed [COEF_W-1:0] ext;
   logic [7:0]               rs;
   logic [6:0]               idx_run;
   logic [6:0]               idx_zrl;
   logic                     bit_take;
   logic                     coef_take;
   logic                     last;

   magnitude_extend #(.COEF_W(COEF_W)) u_ext (
      .raw   (mag_nxt),
      .s     (s_q),
      .value (ext)
   );

   // Bit handshake, decoder forwarding and decode helpers
   always_comb begin
      bit_ready    = (state == ST_MAG) ||
                     ((state == ST_HUFF) && !dec_done);
      dec_is_new   = (state == ST_HUFF) && bit_valid && !dec_done;
      dec_next_bit = dec_is_new && bit_in;
      bit_take     = bit_valid && bit_ready;
      coef_take    = coef_valid && coef_ready;
      busy         = (state != ST_IDLE);
      mag_nxt      = {mag, bit_in};
      rs           = {dec_r, dec_s};
      idx_run      = {1'b0, idx} + {3'b000, dec_r};
      idx_zrl      = {1'b0, idx} + 7'(ZRL_LEN);
      last         = (idx == LAST_IDX);
   end

   // Block sequencer: state, indices, predictor and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         idx            <= '0;
         s_q            <= '0;
         zcnt           <= '0;
         zrl            <= 1'b0;
         mag            <= '0;
         mcnt           <= '0;
         pred           <= '0;
         dec_ac_dc_flag <= 1'b1;
         coef_value     <= '0;
         coef_index     <= '0;
         coef_valid     <= 1'b0;
         block_done     <= 1'b0;
         err            <= 1'b0;
      end else begin
         block_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (pred_clear) pred <= '0;
               if (start) begin
                  state          <= ST_HUFF;
                  dec_ac_dc_flag <= 1'b1;
                  idx            <= '0;
                  err            <= 1'b0;
               end
            end
            ST_HUFF: begin
               if (dec_done) begin
                  s_q        <= dec_s;
                  mag        <= '0;
                  mcnt       <= '0;
                  zrl        <= 1'b0;
                  coef_value <= '0;
                  coef_index <= idx;
                  if (dec_ac_dc_flag) begin
                     dec_ac_dc_flag <= 1'b0;
                     if (dec_s > DC_MAX_S) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                     end else if (dec_s == 4'd0) begin
                        coef_value <= pred;
                        coef_valid <= 1'b1;
                        state      <= ST_EMIT;
                     end else begin
                        state <= ST_MAG;
                     end
                  end else if (rs == EOB_RS) begin
                     coef_valid <= 1'b1;
                     state      <= ST_FILL;
                  end else if (rs == ZRL_RS) begin
                     if (idx_zrl > 7'(LAST_IDX)) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                     end else begin
                        zcnt       <= 5'(ZRL_LEN);
                        zrl        <= 1'b1;
                        coef_valid <= 1'b1;
                        state      <= ST_ZRUN;
                     end
                  end else if (dec_s == 4'd0 ||
                               dec_s > AC_MAX_S ||
                               idx_run > 7'(LAST_IDX)) begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end else if (dec_r == 4'd0) begin
                     state <= ST_MAG;
                  end else begin
                     zcnt       <= {1'b0, dec_r};
                     coef_valid <= 1'b1;
                     state      <= ST_ZRUN;
                  end
               end
            end
            ST_MAG: begin
               if (bit_take) begin
                  mag  <= mag_nxt[MAG_W-2:0];
                  mcnt <= mcnt + 4'd1;
                  if (mcnt + 4'd1 == s_q) begin
                     coef_value <= (idx == 6'd0) ? pred + ext : ext;
                     coef_index <= idx;
                     coef_valid <= 1'b1;
                     state      <= ST_EMIT;
                  end
               end
            end
            ST_EMIT: begin
               if (coef_take) begin
                  idx        <= idx + 6'd1;
                  coef_valid <= 1'b0;
                  if (idx == 6'd0) pred <= coef_value;
                  if (last) begin
                     block_done <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     state <= ST_HUFF;
                  end
               end
            end
            ST_ZRUN: begin
               if (coef_take) begin
                  idx        <= idx + 6'd1;
                  coef_index <= idx + 6'd1;
                  zcnt       <= zcnt - 5'd1;
                  if (zcnt == 5'd1) begin
                     coef_valid <= 1'b0;
                     state      <= zrl ? ST_HUFF : ST_MAG;
                  end
               end
            end
            ST_FILL: begin
               if (coef_take) begin
                  idx        <= idx + 6'd1;
                  coef_index <= idx + 6'd1;
                  if (last) begin
                     coef_valid <= 1'b0;
                     block_done <= 1'b1;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_entropy_block_sequencer.sv
// Bench for entropy_block_sequencer: fake Huffman decoder plus
// a block-level coefficient model built from the JPEG rules.
module tb_entropy_block_sequencer;

   localparam int COEF_W = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              pred_clear;
   logic              bit_in;
   logic              bit_valid;
   logic              bit_ready;
   logic              dec_ac_dc_flag;
   logic              dec_next_bit;
   logic              dec_is_new;
   logic [3:0]        dec_r;
   logic [3:0]        dec_s;
   logic              dec_done;
   logic [COEF_W-1:0] coef_value;
   logic [5:0]        coef_index;
   logic              coef_valid;
   logic              coef_ready;
   logic              block_done;
   logic              busy;
   logic              err;

   typedef struct packed {
      logic [2:0] len;
      logic [3:0] r;
      logic [3:0] s;
   } code_t;

   code_t codeq[$];
   bit    bitq[$];
   int    expv[64];
   int    pos;
   int    exp_n;
   int    pred_m;
   int    nvec;
   int    nerr;

   entropy_block_sequencer #(.COEF_W(COEF_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .pred_clear     (pred_clear),
      .bit_in         (bit_in),
      .bit_valid      (bit_valid),
      .bit_ready      (bit_ready),
      .dec_ac_dc_flag (dec_ac_dc_flag),
      .dec_next_bit   (dec_next_bit),
      .dec_is_new     (dec_is_new),
      .dec_r          (dec_r),
      .dec_s          (dec_s),
      .dec_done       (dec_done),
      .coef_value     (coef_value),
      .coef_index     (coef_index),
      .coef_valid     (coef_valid),
      .coef_ready     (coef_ready),
      .block_done     (block_done),
      .busy           (busy),
      .err            (err)
   );

   always #5 clk = ~clk;

   function automatic int wrap(input int v);
      int w;
      w = v % 4096;
      if (w < 0) w += 4096;
      if (w >= 2048) w -= 4096;
      return w;
   endfunction

   function automatic int extend(input int s, input int m);
      if (s == 0) return 0;
      if (m >= (1 << (s - 1))) return m;
      return m - (1 << s) + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      nvec++;
      assert (obs === want) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "/bit_ready"}, 32'(bit_ready), 0);
      chk({tag, "/dec_is_new"}, 32'(dec_is_new), 0);
      chk({tag, "/dec_next_bit"}, 32'(dec_next_bit), 0);
      chk({tag, "/coef_valid"}, 32'(coef_valid), 0);
      chk({tag, "/coef_value"}, 32'(coef_value), 0);
      chk({tag, "/coef_index"}, 32'(coef_index), 0);
      chk({tag, "/block_done"}, 32'(block_done), 0);
      chk({tag, "/busy"}, 32'(busy), 0);
      chk({tag, "/err"}, 32'(err), 0);
      chk({tag, "/flag"}, 32'(dec_ac_dc_flag), 1);
   endtask

   task automatic idle_inputs();
      start      = 1'b0;
      pred_clear = 1'b0;
      bit_valid  = 1'b0;
      dec_done   = 1'b0;
      coef_ready = 1'b0;
   endtask

   task automatic add_code(input int r, input int s, input int m);
      code_t c;
      int    len;
      len   = $urandom_range(1, 4);
      c.len = 3'(len);
      c.r   = 4'(r);
      c.s   = 4'(s);
      codeq.push_back(c);
      for (int i = 0; i < len; i++)
         bitq.push_back(1'($urandom_range(0, 1)));
      for (int i = s - 1; i >= 0; i--)
         bitq.push_back(1'((m >> i) & 1));
   endtask

   task automatic new_block();
      codeq.delete();
      bitq.delete();
      for (int i = 0; i < 64; i++) expv[i] = 0;
      pos   = 0;
      exp_n = 64;
   endtask

   task automatic dc_code(input int s, input int m, input bit clr);
      if (clr) pred_m = 0;
      pred_m  = wrap(pred_m + extend(s, m));
      expv[0] = pred_m;
      pos     = 1;
      add_code(0, s, m);
   endtask

   task automatic ac_code(input int r, input int s, input int m);
      pos       = pos + r;
      expv[pos] = extend(s, m);
      pos       = pos + 1;
      add_code(r, s, m);
   endtask

   task automatic zrl_code();
      pos = pos + 16;
      add_code(15, 0, 0);
   endtask

   task automatic eob_code();
      add_code(0, 0, 0);
   endtask

   task automatic bad_code(input int r, input int s);
      exp_n = pos;
      add_code(r, s, 0);
   endtask

   task automatic rand_block(input bit clr);
      int s, r, lim, k;
      new_block();
      s = $urandom_range(0, 11);
      dc_code(s, $urandom_range(0, (1 << s) - 1), clr);
      while (pos < 64) begin
         k = $urandom_range(0, 9);
         if (k == 0) begin
            eob_code();
            break;
         end
         if (k == 1 && pos + 16 <= 63) begin
            zrl_code();
         end else begin
            lim = 63 - pos;
            if (lim > 15) lim = 15;
            r = $urandom_range(0, lim);
            s = $urandom_range(1, 10);
            ac_code(r, s, $urandom_range(0, (1 << s) - 1));
         end
      end
   endtask

   task automatic run_block(input bit clr, input bit exp_err,
                            input int rdy_pct, input int bv_pct,
                            input int rst_at, input string tag);
      int                n, bd, ncode, ccnt, want;
      bit                bx, cx, dn, stalled, done;
      logic [COEF_W-1:0] hv;
      logic [5:0]        hi;
      n = 0; bd = 0; ncode = 0; ccnt = 0;
      stalled = 1'b0; done = 1'b0;
      @(negedge clk);
      idle_inputs();
      start      = 1'b1;
      pred_clear = clr;
      @(negedge clk);
      start      = 1'b0;
      pred_clear = 1'b0;
      chk({tag, "/busy"}, 32'(busy), 1);
      chk({tag, "/err_clr"}, 32'(err), 0);
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         if (block_done) bd++;
         if (!busy) begin
            idle_inputs();
            done = 1'b1;
         end else if (n == rst_at) begin
            idle_inputs();
            rst = 1'b1;
            @(negedge clk);
            rst    = 1'b0;
            pred_m = 0;
            check_reset({tag, "/rst"});
            exp_n = rst_at;
            done  = 1'b1;
         end else begin
            if (stalled) begin
               chk({tag, "/hold_v"}, 32'(coef_valid), 1);
               chk({tag, "/hold_val"}, 32'(coef_value), 32'(hv));
               chk({tag, "/hold_idx"}, 32'(coef_index), 32'(hi));
            end
            bit_valid = (bitq.size() > 0) &&
                        ($urandom_range(0, 99) < bv_pct);
            bit_in = (bitq.size() > 0) ? bitq[0]
                                       : 1'($urandom_range(0, 1));
            dec_done = (codeq.size() > 0) &&
                       (ccnt == int'(codeq[0].len));
            dec_r = (codeq.size() > 0) ? codeq[0].r : 4'd7;
            dec_s = (codeq.size() > 0) ? codeq[0].s : 4'd3;
            coef_ready = ($urandom_range(0, 99) < rdy_pct);
            start      = ($urandom_range(0, 9) == 0);
            pred_clear = ($urandom_range(0, 9) == 0);
            #1;
            bx = bit_valid && bit_ready;
            cx = coef_valid && coef_ready;
            dn = dec_is_new;
            if (dec_done)
               chk({tag, "/rdy_done"}, 32'(bit_ready), 0);
            if (dn) begin
               chk({tag, "/fwd_bit"}, 32'(dec_next_bit), 32'(bit_in));
               chk({tag, "/fwd_acc"}, 32'(bx), 1);
               chk({tag, "/flag"}, 32'(dec_ac_dc_flag),
                   32'(ncode == 0));
               ccnt++;
            end
            if (bx) void'(bitq.pop_front());
            if (dec_done) begin
               void'(codeq.pop_front());
               ccnt = 0;
               ncode++;
            end
            stalled = coef_valid && !coef_ready;
            hv      = coef_value;
            hi      = coef_index;
            if (cx) begin
               want = (n < 64) ? expv[n] : 0;
               chk({tag, "/index"}, 32'(coef_index), 32'(n));
               chk({tag, "/value"}, 32'(coef_value),
                   32'(want & 32'hFFF));
               n++;
            end
            @(negedge clk);
         end
      end
      if (!done) begin
         chk({tag, "/timeout"}, 0, 1);
         idle_inputs();
         rst = 1'b1;
         @(negedge clk);
         rst    = 1'b0;
         pred_m = 0;
      end
      chk({tag, "/count"}, 32'(n), 32'(exp_n));
      chk({tag, "/done_pulses"}, 32'(bd),
          32'((rst_at < 0 && !exp_err) ? 1 : 0));
      chk({tag, "/err"}, 32'(err), 32'(exp_err));
      @(negedge clk);
      chk({tag, "/done_low"}, 32'(block_done), 0);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      pred_m = 0;
      rst = 1'b1;
      bit_in = 1'b0;
      dec_r = 4'd0;
      dec_s = 4'd0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      new_block();
      dc_code(3, 5, 1'b0);
      eob_code();
      run_block(1'b0, 1'b0, 100, 100, -1, "dc5");

      new_block();
      dc_code(2, 1, 1'b0);
      ac_code(2, 1, 0);
      zrl_code();
      ac_code(0, 4, 15);
      eob_code();
      run_block(1'b0, 1'b0, 60, 70, -1, "dcm2");

      new_block();
      dc_code(0, 0, 1'b0);
      zrl_code();
      ac_code(0, 4, 15);
      eob_code();
      run_block(1'b0, 1'b0, 50, 60, -1, "zrl");

      for (int b = 0; b < 20; b++) begin
         rand_block(b == 5);
         run_block(b == 5, 1'b0, $urandom_range(30, 100),
                   $urandom_range(40, 100), -1, "rand");
      end

      new_block();
      dc_code(1, 1, 1'b0);
      bad_code(14, 0);
      run_block(1'b0, 1'b1, 80, 80, -1, "err_r14");

      new_block();
      dc_code(0, 0, 1'b0);
      zrl_code();
      zrl_code();
      zrl_code();
      ac_code(10, 1, 1);
      bad_code(5, 1);
      run_block(1'b0, 1'b1, 70, 70, -1, "err_ovr");

      new_block();
      dc_code(0, 0, 1'b0);
      eob_code();
      run_block(1'b0, 1'b0, 70, 70, -1, "pred_keep");

      new_block();
      dc_code(4, 9, 1'b0);
      zrl_code();
      ac_code(0, 4, 15);
      eob_code();
      run_block(1'b0, 1'b0, 100, 100, 3, "rst_zrun");

      new_block();
      dc_code(0, 0, 1'b0);
      eob_code();
      run_block(1'b0, 1'b0, 80, 80, -1, "pred_rst");

      new_block();
      dc_code(3, 6, 1'b0);
      eob_code();
      run_block(1'b0, 1'b0, 80, 80, -1, "pred_seed");

      new_block();
      dc_code(3, 2, 1'b1);
      eob_code();
      run_block(1'b1, 1'b0, 80, 80, -1, "clr_start");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/entropy_block_sequencer.md
# entropy_block_sequencer

Sequences the Huffman decoder through one 8x8 block of JPEG entropy-coded data: one DC code, then AC codes until EOB or 64 coefficients. It feeds bits to the decoder and selects the DC or AC table. It reads the magnitude bits that follow each code, applies JPEG sign extension and DC prediction, and expands zero runs. It emits exactly 64 zig-zag-ordered coefficients per block to the dequantiser.

## Interface
- `COEF_W`, default 12: signed coefficient and DC predictor width.
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: begin one block. Sampled only in IDLE.
- `pred_clear`, input, 1: zero the DC predictor (restart interval). Sampled only in IDLE.
- `bit_in`, input, 1: next bit of the entropy-coded stream.
- `bit_valid`, input, 1: `bit_in` is valid.
- `bit_ready`, output, 1: this block consumes `bit_in` this cycle when `bit_valid` is also high.
- `dec_ac_dc_flag`, output, 1: decoder table select. 1 = DC table, 0 = AC table.
- `dec_next_bit`, output, 1: bit forwarded to the decoder.
- `dec_is_new`, output, 1: `dec_next_bit` is valid.
- `dec_r`, input, 4: decoder run value.
- `dec_s`, input, 4: decoder size value.
- `dec_done`, input, 1: `dec_r` and `dec_s` are valid.
- `coef_value`, output, `COEF_W`: signed coefficient.
- `coef_index`, output, 6: zig-zag index, 0..63.
- `coef_valid`, output, 1: coefficient present.
- `coef_ready`, input, 1: downstream accepts the coefficient.
- `block_done`, output, 1: single-cycle pulse after index 63 is accepted.
- `busy`, output, 1: state is not IDLE.
- `err`, output, 1: sticky protocol error. Cleared by `rst` or by an accepted `start`.

## Operation
- The states are IDLE, HUFF, MAG, EMIT, ZRUN and FILL.
- IDLE
  - `start` goes to HUFF with the DC table selected and `idx` = 0.
  - `pred_clear` sets `pred` = 0. If both are high in the same cycle, the clear applies first.
- HUFF
  - `bit_ready` = 1.
  - Each accepted bit is forwarded combinationally: `dec_is_new` = `bit_valid`, `dec_next_bit` = `bit_in`.
  - On `dec_done` in a cycle where `dec_is_new` = 0, latch `r` and `s`. `bit_ready` is forced to 0 in any cycle where `dec_done` = 1.
  - DC phase:
    - `s` > 11 is an error.
    - `s` = 0 means diff = 0; go to EMIT.
    - Otherwise go to MAG.
  - AC phase, checked in this order:
    - `r` = 0, `s` = 0 (EOB): go to FILL.
    - `r` = 15, `s` = 0 (ZRL): go to ZRUN with `zcnt` = 16.
    - `s` = 0 with `r` not 0 or 15, or `s` > 10: error.
    - `idx` + `r` > 63: error.
    - Otherwise go to ZRUN with `zcnt` = `r`, or straight to MAG if `r` = 0.
- MAG
  - `bit_ready` = 1; `dec_is_new` = 0.
  - Shift in `s` bits, MSB first.
  - Value: if the first bit is 1, value = bits. Otherwise value = bits − (2^s − 1).
  - Go to EMIT.
- EMIT
  - `coef_valid` = 1.
  - DC: `coef_value` = `pred` + diff, taken modulo 2^`COEF_W`, and `pred` takes that value on acceptance.
  - AC: `coef_value` = value.
  - On acceptance, `idx`++. Then:
    - After index 63: pulse `block_done`, go to IDLE.
    - Otherwise go to HUFF with the AC table selected.
- ZRUN
  - Emit zeros, one per accepted beat, and decrement `zcnt`.
  - When `zcnt` reaches 0, go to MAG. For ZRL, go to HUFF instead.
  - A ZRL that reaches index 64 is an error.
- FILL
  - Emit zeros until index 63 is accepted, then pulse `block_done` and go to IDLE.
  - An EOB at `idx` = 64 cannot occur, because the block ends at 63.
- Error
  - Set `err`, drop `coef_valid`, go to IDLE without `block_done`.
  - `pred` is unchanged. Decoder state recovery is the upstream restart's responsibility.
- `dec_ac_dc_flag`
  - 1 from `start` until the DC code completes, else 0.
  - Stable across every bit of a code.
- Mid-block `rst` returns to IDLE, clears `pred` and `err`, and discards the partial block.

## Timing
- Reset values:
  - `bit_ready`, `dec_is_new`, `dec_next_bit`, `coef_valid` = 0.
  - `coef_value`, `coef_index` = 0.
  - `block_done`, `busy`, `err` = 0.
  - `dec_ac_dc_flag` = 1.
- Handshakes:
  - A bit transfers when `bit_valid` and `bit_ready` are both high.
  - A coefficient transfers when `coef_valid` and `coef_ready` are both high.
  - `coef_value` and `coef_index` hold stable while `coef_valid` is high and `coef_ready` is low.
- Throughput: one bit or one coefficient per cycle at best.
  - HUFF to MAG or ZRUN: 1 cycle after `dec_done`.
  - MAG to EMIT: 1 cycle after the s-th bit.
- Minimum block of DC s = 0 followed by EOB: 64 coefficient beats plus the code bits plus 3 cycles.
- `block_done` is asserted in the cycle after the index-63 transfer. `busy` falls in that same cycle.
- `start` may be accepted in the cycle immediately after `block_done`.

## Structure
- Shared package `jpeg_pkg`:
  - State enum.
  - `BLOCK_LEN` = 64.
  - `EOB_RS` = 8'h00, `ZRL_RS` = 8'hF0.
  - `DC_MAX_S` = 11, `AC_MAX_S` = 10.
- One sub-module, `magnitude_extend`: combinational conversion of (raw bits, `s`) to a signed `COEF_W` value.

## Test plan
- DC code with `s` = 3, bits 101, `pred` = 0, then EOB → index 0 = 5, indices 1..63 = 0, one `block_done`, `pred` = 5.
- Second block: DC `s` = 2, bits 01 (diff = −2) → index 0 = 3.
- AC `r` = 2, `s` = 1, bit 0 → indices 1, 2 = 0 and index 3 = −1.
- ZRL, then `r` = 0, `s` = 4, bits 1111 → indices 1..16 = 0 and index 17 = 15.
- `coef_ready` toggled randomly → outputs held stable while stalled and exactly 64 transfers per block. `bit_valid` gaps leave the coefficient sequence unchanged.
- Errors → `err` = 1 and no `block_done`:
  - `r` = 14, `s` = 0.
  - Overrun with `idx` = 60 and `r` = 5.
- `rst` during ZRUN → IDLE next cycle, all outputs at reset values.
- `start` while busy → ignored.
